// File: rtl/rect_rasterizer_if.sv
// rect_rasterizer_if
//   Bundles the rectangle request and the pixel stream of rect_rasterizer.
//   master : request side (drives start/coords/colour, observes the stream)
//   slave  : rasterizer side (observes the request, drives busy/pixels/frame_ready)
//   Signals:
//     start, x0, x1, y0, y1, r, g, b, a     request and fill colour
//     busy, pixel_ready, pixel_number,      pixel stream and status
//     o_r, o_g, o_b, o_a, frame_ready
interface rect_rasterizer_if;
    logic        start;
    logic [9:0]  x0, x1;
    logic [8:0]  y0, y1;
    logic [7:0]  r, g, b, a;
    logic        busy;
    logic [18:0] pixel_number;
    logic        pixel_ready;
    logic [7:0]  o_r, o_g, o_b, o_a;
    logic        frame_ready;

    modport master (
        output start, x0, x1, y0, y1, r, g, b, a,
        input  busy, pixel_number, pixel_ready, o_r, o_g, o_b, o_a, frame_ready
    );
    modport slave (
        input  start, x0, x1, y0, y1, r, g, b, a,
        output busy, pixel_number, pixel_ready, o_r, o_g, o_b, o_a, frame_ready
    );
endinterface

// File: rtl/rect_rasterizer.sv
// rect_rasterizer
//   Clips a screen-space rectangle to the screen and walks it in raster order,
//   emitting one pixel_ready strobe per pixel every PIXEL_GAP cycles, followed
//   by a single frame_ready pulse. All outputs are registered.
//   Ports:
//     clk    in  system clock, rising edge
//     reset  in  synchronous active-high reset
//     bus    slave modport of rect_rasterizer_if (request in, pixel stream out)
module rect_rasterizer #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int PIXEL_GAP = 2
) (
    input  logic              clk,
    input  logic              reset,
    rect_rasterizer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} state_t;

    localparam int          GW       = (PIXEL_GAP > 2) ? $clog2(PIXEL_GAP) : 1;
    localparam logic [9:0]  XMAX     = 10'(SCREEN_W - 1);
    localparam logic [8:0]  YMAX     = 9'(SCREEN_H - 1);
    localparam logic [18:0] ROW      = 19'(SCREEN_W);
    localparam logic [GW-1:0] GAP_LAST = GW'((PIXEL_GAP >= 2) ? PIXEL_GAP - 2 : 0);

    state_t        state_q, state_d;
    logic [9:0]    x_q, x_d, x0_q, x0_d, x1c_q, x1c_d;
    logic [8:0]    y_q, y_d, y1c_q, y1c_d;
    logic [18:0]   row_q, row_d, pn_q, pn_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   col_q, col_d;
    logic          pr_q, pr_d, fr_q, fr_d, busy_q, busy_d;

    // request decode: clip the far corner, detect an empty rectangle
    logic [9:0]  x1c_in;
    logic [8:0]  y1c_in;
    logic [18:0] row_in;
    logic        empty_in;
    assign x1c_in   = (bus.x1 > XMAX) ? XMAX : bus.x1;
    assign y1c_in   = (bus.y1 > YMAX) ? YMAX : bus.y1;
    assign row_in   = ROW * 19'(bus.y0);
    assign empty_in = (bus.x0 > x1c_in) || (bus.y0 > y1c_in);

    // raster step from the pixel just emitted; rows advance by an add
    logic        last;
    logic [9:0]  nx;
    logic [8:0]  ny;
    logic [18:0] nrow;
    assign last = (x_q == x1c_q) && (y_q == y1c_q);
    always_comb begin
        nx   = x_q + 10'd1;
        ny   = y_q;
        nrow = row_q;
        if (x_q == x1c_q) begin
            nx   = x0_q;
            ny   = y_q + 9'd1;
            nrow = row_q + ROW;
        end
    end

    always_comb begin
        logic adv;
        adv     = 1'b0;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x1c_d   = x1c_q;
        y1c_d   = y1c_q;
        row_d   = row_q;
        pn_d    = pn_q;
        gap_d   = gap_q;
        col_d   = col_q;
        pr_d    = 1'b0;
        fr_d    = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    busy_d = 1'b1;
                    x0_d   = bus.x0;
                    x1c_d  = x1c_in;
                    y1c_d  = y1c_in;
                    x_d    = bus.x0;
                    y_d    = bus.y0;
                    row_d  = row_in;
                    col_d  = {bus.r, bus.g, bus.b, bus.a};
                    if (empty_in) begin
                        state_d = DONE;
                        fr_d    = 1'b1;
                    end else begin
                        state_d = EMIT;
                        pr_d    = 1'b1;
                        pn_d    = row_in + 19'(bus.x0);
                    end
                end
            end
            EMIT: begin
                if (PIXEL_GAP == 1) begin
                    adv = 1'b1;
                end else begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) adv = 1'b1;
                else                   gap_d = gap_q + GW'(1);
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (last) begin
                state_d = DONE;
                fr_d    = 1'b1;
            end else begin
                state_d = EMIT;
                pr_d    = 1'b1;
                x_d     = nx;
                y_d     = ny;
                row_d   = nrow;
                pn_d    = nrow + 19'(nx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1c_q   <= '0;
            y1c_q   <= '0;
            row_q   <= '0;
            pn_q    <= '0;
            gap_q   <= '0;
            col_q   <= '0;
            pr_q    <= 1'b0;
            fr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x1c_q   <= x1c_d;
            y1c_q   <= y1c_d;
            row_q   <= row_d;
            pn_q    <= pn_d;
            gap_q   <= gap_d;
            col_q   <= col_d;
            pr_q    <= pr_d;
            fr_q    <= fr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.pixel_ready  = pr_q;
    assign bus.frame_ready  = fr_q;
    assign bus.pixel_number = pn_q;
    assign bus.o_r          = col_q[31:24];
    assign bus.o_g          = col_q[23:16];
    assign bus.o_b          = col_q[15:8];
    assign bus.o_a          = col_q[7:0];
endmodule

// File: tb/tb_rect_rasterizer.sv
module tb_rect_rasterizer;
    localparam int W = 640, H = 480, GAP = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rect_rasterizer_if bus();
    rect_rasterizer_if bus1();

    rect_rasterizer #(.SCREEN_W(W), .SCREEN_H(H), .PIXEL_GAP(GAP)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    rect_rasterizer #(.SCREEN_W(W), .SCREEN_H(H), .PIXEL_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        bit          frame;
        int          cyc;
        int          pn;
        logic [31:0] col;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0, errors = 0;
    int  bz_lo = 1, bz_hi = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // expected pixel stream for one accepted rectangle, first event at ts
    task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                             input logic [31:0] col, input int ts);
        int x1c, y1c, n;
        ev_t e;
        x1c = (x1 > W - 1) ? W - 1 : x1;
        y1c = (y1 > H - 1) ? H - 1 : y1;
        n = 0;
        for (int y = y0; y <= y1c; y++)
            for (int x = x0; x <= x1c; x++) begin
                e = '{frame: 1'b0, cyc: ts + n * GAP, pn: y * W + x, col: col};
                sb.push_back(e);
                n++;
            end
        e = '{frame: 1'b1, cyc: ts + n * GAP, pn: 0, col: col};
        sb.push_back(e);
        bz_lo = ts;
        bz_hi = ts + n * GAP;
    endtask

    // one-cycle start pulse; inputs scrambled afterwards to prove they were latched
    task automatic drive(input int x0, input int y0, input int x1, input int y1,
                         input logic [31:0] col, input bit accept);
        bus.x0 = 10'(x0); bus.y0 = 9'(y0);
        bus.x1 = 10'(x1); bus.y1 = 9'(y1);
        {bus.r, bus.g, bus.b, bus.a} = col;
        bus.start = 1'b1;
        if (accept) push_rect(x0, y0, x1, y1, col, cyc + 1);
        step();
        bus.start = 1'b0;
        bus.x0 = 10'($urandom); bus.y0 = 9'($urandom);
        bus.x1 = 10'($urandom); bus.y1 = 9'($urandom);
        {bus.r, bus.g, bus.b, bus.a} = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 400) begin
            step();
            n++;
        end
        chk("idle_timeout", 64'(n < 400), 64'd1);
        step();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            chk("busy", 64'(bus.busy), 64'(cyc >= bz_lo && cyc <= bz_hi));
            if (bus.pixel_ready)
                chk("pn_range", 64'(bus.pixel_number <= 19'd307199), 64'd1);
            if (bus.pixel_ready || bus.frame_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 64'({bus.frame_ready, bus.pixel_ready}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", 64'({bus.frame_ready, bus.pixel_ready}),
                        64'(e.frame ? 2'b10 : 2'b01));
                    chk("event_cycle", 64'(cyc), 64'(e.cyc));
                    if (!e.frame) begin
                        chk("pixel_number", 64'(bus.pixel_number), 64'(e.pn));
                        chk("colour", 64'({bus.o_r, bus.o_g, bus.o_b, bus.o_a}), 64'(e.col));
                    end
                end
            end
        end
    end

    initial begin
        int ts;
        bus.start = 1'b0; bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;
        {bus.r, bus.g, bus.b, bus.a} = '0;
        bus1.start = 1'b0; bus1.x0 = '0; bus1.x1 = '0; bus1.y0 = '0; bus1.y1 = '0;
        {bus1.r, bus1.g, bus1.b, bus1.a} = '0;

        // reset state
        repeat (3) step();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_pixel_ready", 64'(bus.pixel_ready), 64'd0);
        chk("rst_frame_ready", 64'(bus.frame_ready), 64'd0);
        chk("rst_pixel_number", 64'(bus.pixel_number), 64'd0);
        chk("rst_colour", 64'({bus.o_r, bus.o_g, bus.o_b, bus.o_a}), 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        step();

        // basic walk
        drive(2, 1, 4, 2, 32'h8040C011, 1'b1);
        wait_idle();

        // clipping at the bottom-right corner
        drive(638, 478, 1000, 500, 32'h12345678, 1'b1);
        wait_idle();

        // empty and degenerate rectangles
        drive(5, 5, 4, 9, 32'hAABBCCDD, 1'b1);
        wait_idle();
        drive(700, 0, 800, 0, 32'h01020304, 1'b1);
        wait_idle();
        drive(9, 9, 9, 9, 32'hDEADBEEF, 1'b1);
        wait_idle();

        // starts while busy (mid-rectangle and in DONE) are dropped;
        // a start right after DONE is taken
        drive(2, 1, 4, 2, 32'h8040C011, 1'b1);
        ts = cyc;
        while (cyc < ts + 3) step();
        drive(0, 0, 300, 200, 32'hFFFFFFFF, 1'b0);
        while (cyc < ts + 12) step();
        drive(7, 7, 20, 20, 32'hFFFFFFFF, 1'b0);
        drive(1, 0, 1, 0, 32'h55667788, 1'b1);
        wait_idle();

        // reset after the second pixel abandons the rectangle
        drive(2, 1, 4, 2, 32'h8040C011, 1'b1);
        ts = cyc;
        while (cyc < ts + 2) step();
        reset = 1'b1;
        sb.delete();
        bz_lo = 1;
        bz_hi = 0;
        step();
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_pixel_ready", 64'(bus.pixel_ready), 64'd0);
        chk("mid_rst_frame_ready", 64'(bus.frame_ready), 64'd0);
        chk("mid_rst_pixel_number", 64'(bus.pixel_number), 64'd0);
        chk("mid_rst_colour", 64'({bus.o_r, bus.o_g, bus.o_b, bus.o_a}), 64'd0);
        reset = 1'b0;
        repeat (4) step();
        drive(2, 1, 4, 2, 32'h8040C011, 1'b1);
        wait_idle();

        // PIXEL_GAP = 1 instance: back-to-back pixels
        bus1.x0 = 10'd0; bus1.y0 = 9'd0; bus1.x1 = 10'd2; bus1.y1 = 9'd0;
        {bus1.r, bus1.g, bus1.b, bus1.a} = 32'h0A0B0C0D;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("gap1_pixel_ready", 64'(bus1.pixel_ready), 64'(i < 3));
            chk("gap1_frame_ready", 64'(bus1.frame_ready), 64'(i == 3));
            chk("gap1_busy", 64'(bus1.busy), 64'd1);
            if (i < 3) chk("gap1_pixel_number", 64'(bus1.pixel_number), 64'(i));
            step();
        end
        chk("gap1_busy_end", 64'(bus1.busy), 64'd0);
        chk("gap1_colour", 64'({bus1.o_r, bus1.o_g, bus1.o_b, bus1.o_a}), 64'h0A0B0C0D);

        mon_en = 1'b0;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
